// File: rtl/icache_mshr_ooo.sv
// icache_mshr_ooo: icache miss status holding register with out-of-order retirement,
// multi-port duplicate-miss snoop, squash and per-entry watchdog.
module icache_mshr_ooo #(
  parameter int NUM_ENTRIES    = 8,
  parameter int TAG_W          = 4,
  parameter int ITAG_W         = 13,
  parameter int SNOOP_PORTS    = 2,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                          clock,
  input  logic                          reset_n,
  input  logic [SNOOP_PORTS-1:0]        snoop_valid,
  input  logic [SNOOP_PORTS*ITAG_W-1:0] snoop_itag,
  output logic [SNOOP_PORTS-1:0]        snoop_hit,
  input  logic                          alloc_valid,
  input  logic [TAG_W-1:0]              alloc_mem_tag,
  input  logic [ITAG_W-1:0]             alloc_itag,
  output logic                          alloc_ready,
  output logic                          alloc_err,
  input  logic [TAG_W-1:0]              resp_tag,
  output logic                          fill_valid,
  output logic [ITAG_W-1:0]             fill_itag,
  input  logic                          flush,
  output logic [$clog2(NUM_ENTRIES+1)-1:0] count,
  output logic                          timeout_err
);
  localparam int CW = $clog2(NUM_ENTRIES+1);
  localparam int AW = TIMEOUT_CYCLES > 0 ? $clog2(TIMEOUT_CYCLES+1) : 1;
  localparam int IW = $clog2(NUM_ENTRIES);
  logic [NUM_ENTRIES-1:0] occ, live, match, tmo, freed, tag_dup, itag_dup, ins, occ_n;
  logic [TAG_W-1:0]  tag_q  [NUM_ENTRIES];
  logic [ITAG_W-1:0] itag_q [NUM_ENTRIES];
  logic [AW-1:0]     age_q  [NUM_ENTRIES];
  logic [IW-1:0]     slot;
  logic [CW-1:0]     cnt_n;
  logic              err, accept;
  for (genvar e = 0; e < NUM_ENTRIES; e++) begin : g_ent
    assign match[e]    = occ[e] && resp_tag != '0 && tag_q[e] == resp_tag;
    assign tmo[e]      = TIMEOUT_CYCLES != 0 && occ[e] && age_q[e] == AW'(TIMEOUT_CYCLES);
    assign tag_dup[e]  = occ[e] && !freed[e] && tag_q[e] == alloc_mem_tag;
    assign itag_dup[e] = live[e] && !freed[e] && itag_q[e] == alloc_itag;
  end
  assign freed       = match | tmo;
  assign alloc_ready = count < CW'(NUM_ENTRIES);
  assign err         = alloc_valid && (!alloc_ready || alloc_mem_tag == '0 || |tag_dup || |itag_dup);
  assign accept      = alloc_valid && !err;
  assign fill_valid  = |(match & live);
  assign ins         = accept ? NUM_ENTRIES'(1) << slot : '0;
  assign occ_n       = (occ & ~freed) | ins;
  // Entries freed this cycle stay occupied in occ, so they cannot be picked as the slot.
  always_comb begin
    slot = '0;
    for (int i = NUM_ENTRIES-1; i >= 0; i--)
      if (!occ[i]) slot = IW'(i);
  end
  always_comb begin
    fill_itag = '0;
    cnt_n = '0;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      fill_itag = fill_itag | (match[i] && live[i] ? itag_q[i] : '0);
      cnt_n = cnt_n + CW'(occ_n[i]);
    end
  end
  always_comb begin
    snoop_hit = '0;
    for (int p = 0; p < SNOOP_PORTS; p++)
      for (int i = 0; i < NUM_ENTRIES; i++)
        if (snoop_valid[p] && live[i] && itag_q[i] == snoop_itag[p*ITAG_W +: ITAG_W]) snoop_hit[p] = 1'b1;
  end
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      occ <= '0;
      live <= '0;
      count <= '0;
      alloc_err <= 1'b0;
      timeout_err <= 1'b0;
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        tag_q[i] <= '0;
        itag_q[i] <= '0;
        age_q[i] <= '0;
      end
    end else begin
      occ <= occ_n;
      live <= ((flush ? '0 : live) & ~freed) | ins;
      count <= cnt_n;
      alloc_err <= err;
      timeout_err <= timeout_err | |tmo;
      for (int i = 0; i < NUM_ENTRIES; i++)
        if (ins[i]) begin
          tag_q[i] <= alloc_mem_tag;
          itag_q[i] <= alloc_itag;
          age_q[i] <= '0;
        end else if (occ[i] && age_q[i] != AW'(TIMEOUT_CYCLES)) age_q[i] <= age_q[i] + 1'b1;
    end
endmodule

// File: tb/tb_icache_mshr_ooo.sv
// tb_icache_mshr_ooo: directed stimulus with a fill scoreboard drained by a negedge monitor;
// a second instance with a short watchdog exercises the timeout path.
module tb_icache_mshr_ooo;
  logic        clock = 0;
  logic        reset_n = 0;
  logic [1:0]  sv = '0, sh;
  logic [25:0] si = '0;
  logic        av = 0, ar, ae, fv, fl = 0, te;
  logic [3:0]  amt = '0, rt = '0, cnt;
  logic [12:0] ait = '0, fi;
  logic [1:0]  w_sh;
  logic        w_av = 0, w_ar, w_ae, w_fv, w_te;
  logic [3:0]  w_amt = '0, w_rt = '0, w_cnt;
  logic [12:0] w_fi;
  logic [12:0] exp_fill[$];
  int n_tests = 0, n_fail = 0;
  localparam logic [12:0] A = 13'h0AAA, B = 13'h0BBB, C = 13'h0CCC, D = 13'h0DDD;

  always #5 clock = ~clock;

  icache_mshr_ooo u_dut (
    .clock(clock), .reset_n(reset_n), .snoop_valid(sv), .snoop_itag(si), .snoop_hit(sh),
    .alloc_valid(av), .alloc_mem_tag(amt), .alloc_itag(ait), .alloc_ready(ar), .alloc_err(ae),
    .resp_tag(rt), .fill_valid(fv), .fill_itag(fi), .flush(fl), .count(cnt), .timeout_err(te));

  icache_mshr_ooo #(.TIMEOUT_CYCLES(4)) u_wd (
    .clock(clock), .reset_n(reset_n), .snoop_valid(2'b00), .snoop_itag(26'h0), .snoop_hit(w_sh),
    .alloc_valid(w_av), .alloc_mem_tag(w_amt), .alloc_itag(A), .alloc_ready(w_ar), .alloc_err(w_ae),
    .resp_tag(w_rt), .fill_valid(w_fv), .fill_itag(w_fi), .flush(1'b0), .count(w_cnt),
    .timeout_err(w_te));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clock) if (reset_n && fv) begin
    n_tests++;
    if (exp_fill.size() == 0) begin
      n_fail++;
      $display("FAIL fill_unexpected: got itag %0h expected no fill", fi);
    end else begin
      logic [12:0] e;
      e = exp_fill.pop_front();
      if (fi !== e) begin
        n_fail++;
        $display("FAIL fill_itag: got %0h expected %0h", fi, e);
      end
    end
  end

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic do_alloc(input logic [3:0] t, input logic [12:0] it, input logic e);
    av = 1; amt = t; ait = it;
    tick();
    av = 0;
    chk("alloc_err", ae, e);
  endtask

  task automatic do_resp(input logic [3:0] t, input logic f, input logic [12:0] it);
    rt = t;
    if (f) exp_fill.push_back(it);
    else begin
      #1;
      chk("resp_nofill", fv, 0);
    end
    tick();
    rt = '0;
  endtask

  initial begin
    #2;
    chk("rst_ready", ar, 1);
    chk("rst_err", ae, 0);
    chk("rst_fill", {fv, fi}, 0);
    chk("rst_count", cnt, 0);
    chk("rst_tmo", te, 0);
    chk("rst_snoop", sh, 0);
    tick();
    reset_n = 1;
    tick();
    // 1: out-of-order completion
    do_alloc(1, A, 0);
    chk("t1_cnt1", cnt, 1);
    do_alloc(2, B, 0);
    chk("t1_cnt2", cnt, 2);
    do_resp(2, 1, B);
    chk("t1_cnt_a", cnt, 1);
    do_resp(1, 1, A);
    chk("t1_cnt_b", cnt, 0);
    // 2: full, overflow, same-cycle free not reusable
    for (int i = 1; i <= 8; i++) do_alloc(4'(i), 13'h100 + 13'(i), 0);
    chk("t2_cnt8", cnt, 8);
    chk("t2_notready", ar, 0);
    do_alloc(9, 13'h200, 1);
    chk("t2_cnt_stay", cnt, 8);
    tick();
    chk("t2_err_pulse", ae, 0);
    av = 1; amt = 9; ait = 13'h200; rt = 3;
    exp_fill.push_back(13'h103);
    tick();
    av = 0; rt = 0;
    chk("t2_same_cycle_err", ae, 1);
    chk("t2_cnt7", cnt, 7);
    do_alloc(9, 13'h200, 0);
    chk("t2_cnt8b", cnt, 8);
    for (int i = 1; i <= 9; i++) if (i != 3) do_resp(4'(i), 1, i == 9 ? 13'h200 : 13'h100 + 13'(i));
    chk("t2_drained", cnt, 0);
    // 3: duplicates and tag 0
    do_alloc(3, A, 0);
    do_alloc(5, A, 1);
    do_alloc(3, B, 1);
    do_alloc(0, B, 1);
    chk("t3_cnt1", cnt, 1);
    do_alloc(4, B, 0);
    av = 1; amt = 5; ait = A; rt = 3;
    exp_fill.push_back(A);
    tick();
    av = 0; rt = 0;
    chk("t3_reuse_itag_err", ae, 0);
    chk("t3_cnt2", cnt, 2);
    do_resp(4, 1, B);
    do_resp(5, 1, A);
    chk("t3_drained", cnt, 0);
    // 4: snoop
    do_alloc(1, A, 0);
    sv = 2'b11; si = {C, A};
    av = 1; amt = 2; ait = C;
    #1;
    chk("t4_snoop", sh, 2'b01);
    tick();
    av = 0;
    chk("t4_snoop_next", sh, 2'b11);
    sv = 2'b10;
    #1;
    chk("t4_snoop_gated", sh, 2'b10);
    sv = 2'b00;
    do_resp(1, 1, A);
    do_resp(2, 1, C);
    // 5: flush
    do_alloc(1, A, 0);
    do_alloc(2, B, 0);
    do_alloc(3, C, 0);
    fl = 1; rt = 1; av = 1; amt = 4; ait = D;
    exp_fill.push_back(A);
    tick();
    fl = 0; rt = 0; av = 0;
    chk("t5_flush_alloc", ae, 0);
    chk("t5_cnt3", cnt, 3);
    sv = 2'b11; si = {C, B};
    #1;
    chk("t5_squashed_snoop", sh, 2'b00);
    si = {C, D};
    #1;
    chk("t5_live_snoop", sh, 2'b01);
    sv = 2'b00;
    do_resp(2, 0, 0);
    chk("t5_cnt2", cnt, 2);
    do_resp(3, 0, 0);
    chk("t5_cnt1", cnt, 1);
    do_resp(4, 1, D);
    chk("t5_cnt0", cnt, 0);
    // 6: watchdog on the short-timeout instance
    w_av = 1; w_amt = 1;
    tick();
    w_av = 0;
    chk("t6_err", w_ae, 0);
    chk("t6_cnt1", w_cnt, 1);
    repeat (4) tick();
    chk("t6_cnt_held", w_cnt, 1);
    chk("t6_tmo_clear", w_te, 0);
    tick();
    chk("t6_cnt_freed", w_cnt, 0);
    chk("t6_tmo_set", w_te, 1);
    repeat (3) tick();
    chk("t6_tmo_sticky", w_te, 1);
    w_rt = 1;
    #1;
    chk("t6_late_resp", {w_fv, w_fi}, 0);
    chk("t6_ready", {w_ar, w_sh}, 3'b100);
    tick();
    w_rt = 0;
    chk("main_no_tmo", te, 0);
    chk("scoreboard_empty", exp_fill.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
endmodule
